traffic_light_ctrl: RTL and testbench

Sequencer for a single pedestrian crossing: a Moore FSM with a shared down-counting phase timer that drives the car lamps (red/yellow/green) and pedestrian lamps (red/green). It latches pedestrian button requests and supports a night mode with a flashing car-yellow lamp. It sits between the board clock/reset source and the lamp drivers, and is the top sequential block of the traffic-lights design.

---
 rtl/traffic_light_ctrl_pkg.sv | 47 ++++
 rtl/traffic_light_ctrl_if.sv | 24 ++
 rtl/traffic_light_ctrl_tl_timer.sv | 30 +++
 rtl/traffic_light_ctrl.sv | 149 ++++++++++++++
 tb/tb_traffic_light_ctrl.sv | 177 +++++++++++++++++
 5 files changed

// File: rtl/traffic_light_ctrl_pkg.sv
// Shared types for the pedestrian-crossing sequencer: state codes, lamp-vector
// bit positions and the Moore lamp decode.
package traffic_light_ctrl_pkg;

  typedef enum logic [2:0] {
    CLEAR_A    = 3'd0,
    CAR_GREEN  = 3'd1,
    CAR_YELLOW = 3'd2,
    CLEAR_B    = 3'd3,
    PED_GREEN  = 3'd4,
    NIGHT      = 3'd5
  } tl_state_e;

  localparam int LAMP_W          = 5;
  localparam int LAMP_CAR_RED    = 4;
  localparam int LAMP_CAR_YELLOW = 3;
  localparam int LAMP_CAR_GREEN  = 2;
  localparam int LAMP_PED_RED    = 1;
  localparam int LAMP_PED_GREEN  = 0;

  function automatic logic [LAMP_W-1:0] lamp_decode(tl_state_e st, logic blink);
    logic [LAMP_W-1:0] v;
    v = '0;
    case (st)
      CAR_GREEN: begin
        v[LAMP_CAR_GREEN] = 1'b1;
        v[LAMP_PED_RED]   = 1'b1;
      end
      CAR_YELLOW: begin
        v[LAMP_CAR_YELLOW] = 1'b1;
        v[LAMP_PED_RED]    = 1'b1;
      end
      PED_GREEN: begin
        v[LAMP_CAR_RED]   = 1'b1;
        v[LAMP_PED_GREEN] = 1'b1;
      end
      NIGHT: v[LAMP_CAR_YELLOW] = blink;
      // clearance states and illegal codes both show all-red
      default: begin
        v[LAMP_CAR_RED] = 1'b1;
        v[LAMP_PED_RED] = 1'b1;
      end
    endcase
    return v;
  endfunction

endpackage

// File: rtl/traffic_light_ctrl_if.sv
// Control inputs and lamp outputs of the crossing sequencer; the controller
// side is the slave, the board/test side the master.
interface traffic_light_ctrl_if;
  logic       en;
  logic       ped_req;
  logic       night_mode;
  logic       car_red;
  logic       car_yellow;
  logic       car_green;
  logic       ped_red;
  logic       ped_green;
  logic       ped_wait;
  logic [2:0] state_o;

  modport master (
    output en, ped_req, night_mode,
    input  car_red, car_yellow, car_green, ped_red, ped_green, ped_wait, state_o
  );

  modport slave (
    input  en, ped_req, night_mode,
    output car_red, car_yellow, car_green, ped_red, ped_green, ped_wait, state_o
  );
endinterface

// File: rtl/traffic_light_ctrl_tl_timer.sv
// Loadable phase down-counter; holds at zero and flags expiry while zero.
module tl_timer #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             expired
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= RST_VAL;
    end else if (en) begin
      if (load) begin
        r_count <= load_val;
      end else if (r_count != '0) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  assign expired = (r_count == '0);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Pedestrian-crossing sequencer: Moore FSM over a shared phase timer, with
// latched pedestrian requests and a flashing-yellow night mode.
//   state      | meaning
//   CLEAR_A    | all-red before car green
//   CAR_GREEN  | cars go; exits after min green only on request or night
//   CAR_YELLOW | cars stopping
//   CLEAR_B    | all-red before pedestrian green
//   PED_GREEN  | pedestrians cross
//   NIGHT      | car yellow flashes, everything else dark
module traffic_light_ctrl
  import traffic_light_ctrl_pkg::*;
#(
  parameter int CNT_W       = 8,
  parameter int T_CLEAR     = 2,
  parameter int T_MIN_GREEN = 5,
  parameter int T_YELLOW    = 3,
  parameter int T_PED       = 10,
  parameter int T_BLINK     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  traffic_light_ctrl_if.slave  bus
);

  localparam int T_MAX = (1 << CNT_W) - 1;

  if (T_CLEAR < 1 || T_CLEAR > T_MAX || T_MIN_GREEN < 1 || T_MIN_GREEN > T_MAX ||
      T_YELLOW < 1 || T_YELLOW > T_MAX || T_PED < 1 || T_PED > T_MAX ||
      T_BLINK < 1 || T_BLINK > T_MAX) begin : g_bad_param
    $error("traffic_light_ctrl: phase durations must lie in 1..2^CNT_W-1");
  end

  localparam logic [CNT_W-1:0] LD_CLEAR  = CNT_W'(T_CLEAR - 1);
  localparam logic [CNT_W-1:0] LD_GREEN  = CNT_W'(T_MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] LD_YELLOW = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] LD_PED    = CNT_W'(T_PED - 1);
  localparam logic [CNT_W-1:0] LD_BLINK  = CNT_W'(T_BLINK - 1);

  tl_state_e          r_state;
  tl_state_e          w_state_nxt;
  logic               r_ped_pending;
  logic               r_blink;
  logic               w_blink_nxt;
  logic               w_load;
  logic [CNT_W-1:0]   w_load_val;
  logic               w_expired;
  logic               w_clr_pending;
  logic [LAMP_W-1:0]  w_lamps;

  tl_timer #(
    .CNT_W   (CNT_W),
    .RST_VAL (LD_CLEAR)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (bus.en),
    .load     (w_load),
    .load_val (w_load_val),
    .expired  (w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= CLEAR_A;
      r_blink       <= 1'b0;
      r_ped_pending <= 1'b0;
    end else begin
      if (bus.en) begin
        r_state <= w_state_nxt;
        r_blink <= w_blink_nxt;
      end
      // requests are latched even while frozen; entering service clears them
      if (bus.en && w_clr_pending) begin
        r_ped_pending <= 1'b0;
      end else if (bus.ped_req && r_state != NIGHT) begin
        r_ped_pending <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_blink_nxt = r_blink;
    w_load      = 1'b0;
    w_load_val  = LD_CLEAR;
    case (r_state)
      CLEAR_A: if (w_expired) begin
        w_state_nxt = CAR_GREEN;
        w_load      = 1'b1;
        w_load_val  = LD_GREEN;
      end
      CAR_GREEN: if (w_expired && (r_ped_pending || bus.night_mode)) begin
        w_state_nxt = CAR_YELLOW;
        w_load      = 1'b1;
        w_load_val  = LD_YELLOW;
      end
      CAR_YELLOW: if (w_expired) begin
        w_load = 1'b1;
        if (bus.night_mode) begin
          w_state_nxt = NIGHT;
          w_load_val  = LD_BLINK;
          w_blink_nxt = 1'b1;
        end else begin
          w_state_nxt = CLEAR_B;
          w_load_val  = LD_CLEAR;
        end
      end
      CLEAR_B: if (w_expired) begin
        w_state_nxt = PED_GREEN;
        w_load      = 1'b1;
        w_load_val  = LD_PED;
      end
      PED_GREEN: if (w_expired) begin
        w_state_nxt = CLEAR_A;
        w_load      = 1'b1;
        w_load_val  = LD_CLEAR;
      end
      NIGHT: begin
        if (!bus.night_mode) begin
          w_state_nxt = CLEAR_A;
          w_load      = 1'b1;
          w_load_val  = LD_CLEAR;
        end else if (w_expired) begin
          w_load      = 1'b1;
          w_load_val  = LD_BLINK;
          w_blink_nxt = ~r_blink;
        end
      end
      default: begin
        w_state_nxt = CLEAR_A;
        w_load      = 1'b1;
        w_load_val  = LD_CLEAR;
      end
    endcase
  end

  assign w_clr_pending = (w_state_nxt == PED_GREEN && r_state != PED_GREEN) ||
                         (w_state_nxt == NIGHT && r_state != NIGHT);

  assign w_lamps        = lamp_decode(r_state, r_blink);
  assign bus.car_red    = w_lamps[LAMP_CAR_RED];
  assign bus.car_yellow = w_lamps[LAMP_CAR_YELLOW];
  assign bus.car_green  = w_lamps[LAMP_CAR_GREEN];
  assign bus.ped_red    = w_lamps[LAMP_PED_RED];
  assign bus.ped_green  = w_lamps[LAMP_PED_GREEN];
  assign bus.ped_wait   = r_ped_pending;
  assign bus.state_o    = r_state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed scoreboard bench for traffic_light_ctrl: each stimulus cycle queues
// the expected post-edge outputs, a negedge monitor pops and compares them.
module tb_traffic_light_ctrl;

  localparam int S_CA = 0, S_G = 1, S_Y = 2, S_CB = 3, S_P = 4, S_N = 5;

  typedef struct {
    int         cyc;
    logic [2:0] st;
    logic [4:0] lamps;
    logic       pw;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  traffic_light_ctrl_if bus();

  traffic_light_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // {car_red, car_yellow, car_green, ped_red, ped_green}
  function automatic logic [4:0] exp_lamps(int st, bit yel);
    case (st)
      S_G:     return 5'b00110;
      S_Y:     return 5'b01010;
      S_P:     return 5'b10001;
      S_N:     return {1'b0, yel, 3'b000};
      default: return 5'b10010;
    endcase
  endfunction

  function automatic logic [4:0] act_lamps();
    return {bus.car_red, bus.car_yellow, bus.car_green, bus.ped_red, bus.ped_green};
  endfunction

  task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      exp_t e;
      e = q.pop_front();
      chk("state", 8'(bus.state_o), 8'(e.st));
      chk("lamps", 8'(act_lamps()), 8'(e.lamps));
      chk("ped_wait", 8'(bus.ped_wait), 8'(e.pw));
    end
  end

  task automatic step(bit e, bit p, bit n, int st, bit w, bit y = 1'b0);
    exp_t x;
    bus.en         = e;
    bus.ped_req    = p;
    bus.night_mode = n;
    x.cyc   = cyc + 1;
    x.st    = 3'(st);
    x.lamps = exp_lamps(st, y);
    x.pw    = w;
    q.push_back(x);
    @(posedge clk);
    #1;
  endtask

  task automatic run(int k, bit e, bit p, bit n, int st, bit w);
    for (int i = 0; i < k; i++) step(e, p, n, st, w);
  endtask

  task automatic chk_reset_now();
    chk("rst_state", 8'(bus.state_o), 8'(S_CA));
    chk("rst_lamps", 8'(act_lamps()), 8'(5'b10010));
    chk("rst_wait", 8'(bus.ped_wait), 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.en = 1'b1; bus.ped_req = 1'b0; bus.night_mode = 1'b0;
    #12;
    chk_reset_now();
    @(negedge clk); rst_n = 1'b1; #1;

    // idle: CLEAR_A 2 cycles, green holds with no request
    run(1, 1, 0, 0, S_CA, 0);
    run(1, 1, 0, 0, S_G, 0);
    run(50, 1, 0, 0, S_G, 0);

    // one-cycle request after min green elapsed
    step(1, 1, 0, S_G, 1);
    run(3, 1, 0, 0, S_Y, 1);
    run(2, 1, 0, 0, S_CB, 1);
    run(10, 1, 0, 0, S_P, 0);
    run(2, 1, 0, 0, S_CA, 0);

    // request right after green entry still waits out min green
    step(1, 0, 0, S_G, 0);
    step(1, 1, 0, S_G, 1);
    run(3, 1, 0, 0, S_G, 1);
    run(3, 1, 0, 0, S_Y, 1);
    run(2, 1, 0, 0, S_CB, 1);

    // request on the edge into PED_GREEN is dropped; one during it is kept
    step(1, 1, 0, S_P, 0);
    run(3, 1, 0, 0, S_P, 0);
    step(1, 1, 0, S_P, 1);
    run(5, 1, 0, 0, S_P, 1);
    run(2, 1, 0, 0, S_CA, 1);
    run(5, 1, 0, 0, S_G, 1);
    run(3, 1, 0, 0, S_Y, 1);
    run(2, 1, 0, 0, S_CB, 1);
    run(10, 1, 0, 0, S_P, 0);
    run(2, 1, 0, 0, S_CA, 0);

    // night mode: yellow then flashing, requests ignored, exit to CLEAR_A
    step(1, 0, 0, S_G, 0);
    run(4, 1, 0, 1, S_G, 0);
    run(3, 1, 0, 1, S_Y, 0);
    for (int i = 0; i < 12; i++) step(1, (i == 5), 1, S_N, 0, ((i / 4) % 2) == 0);
    step(1, 0, 0, S_CA, 0);
    step(1, 0, 0, S_CA, 0);
    step(1, 0, 0, S_G, 0);

    // en=0 freezes PED_GREEN for 7 cycles, request still latched meanwhile
    run(4, 1, 0, 0, S_G, 0);
    step(1, 1, 0, S_G, 1);
    run(3, 1, 0, 0, S_Y, 1);
    run(2, 1, 0, 0, S_CB, 1);
    run(3, 1, 0, 0, S_P, 0);
    run(3, 0, 0, 0, S_P, 0);
    step(0, 1, 0, S_P, 1);
    run(3, 0, 0, 0, S_P, 1);
    run(7, 1, 0, 0, S_P, 1);
    run(2, 1, 0, 0, S_CA, 1);
    run(5, 1, 0, 0, S_G, 1);
    step(1, 0, 0, S_Y, 1);

    // asynchronous reset mid-yellow, seen before any clock edge
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk_reset_now();
    @(posedge clk); #1;
    chk_reset_now();
    @(negedge clk); rst_n = 1'b1; #1;
    run(1, 1, 0, 0, S_CA, 0);
    run(3, 1, 0, 0, S_G, 0);

    @(negedge clk); #1;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
